// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter; optional macro LEADING_ZERO_BLANK_EN blanks leading zeros
module bin_to_bcd_seq #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  enable,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   digits
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [IN_W-1:0] bin_q;
  logic [BW-1:0] scratch, adj, result, shown;
  logic [CW-1:0] cnt;
  logic ovf_acc;
  logic last;
  assign last = cnt == CW'(IN_W - 1);
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next-state: start only matters in IDLE, DONE always returns to IDLE
  always_comb
    state_nx = (state == IDLE && start) ? SHIFT :
               (state == SHIFT && last) ? DONE :
               (state == DONE) ? IDLE : state;
  // FSM outputs
  always_comb busy = state != IDLE;
  // add-3 correction of every scratch digit ahead of the shift
  always_comb
    for (int k = 0; k < DIGITS; k++)
      adj[4*k +: 4] = (scratch[4*k +: 4] >= 4'd5) ? scratch[4*k +: 4] + 4'd3 : scratch[4*k +: 4];
  // datapath: capture, shift with overflow detection, result load and done pulse
  always_ff @(posedge clk)
    if (rst) begin
      bin_q    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= state == DONE;
      if (state == IDLE && start) begin
        bin_q   <= bin_in;
        scratch <= '0;
        cnt     <= '0;
        ovf_acc <= 1'b0;
      end else if (state == SHIFT) begin
        scratch <= {adj[BW-2:0], bin_q[IN_W-1]};
        bin_q   <= bin_q << 1;
        cnt     <= cnt + 1'b1;
        ovf_acc <= ovf_acc | adj[BW-1];
      end else if (state == DONE) begin
        result   <= ovf_acc ? {DIGITS{4'h9}} : scratch;
        overflow <= ovf_acc;
      end
    end
  // display mapping: optional leading-zero blanking, then enable blanking on top
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    shown = result;
    lead  = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      lead = lead && (result[4*k +: 4] == 4'h0);
      if (lead) shown[4*k +: 4] = 4'hF;
    end
`else
    shown = result;
`endif
    digits = enable ? shown : '1;
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: randomized and directed checks of bin_to_bcd_seq against a decimal reference model
module tb_bin_to_bcd_seq;
  logic clk = 0, rst = 1, start = 0, enable = 1;
  logic [15:0] bin_in = 0;
  logic busy5, done5, ovf5, busy4, done4, ovf4;
  logic [19:0] dig5;
  logic [15:0] dig4;
  int passed = 0, total = 0;

  bin_to_bcd_seq #(.IN_W(16), .DIGITS(5)) u5 (.clk(clk), .rst(rst), .start(start), .enable(enable),
    .bin_in(bin_in), .busy(busy5), .done(done5), .overflow(ovf5), .digits(dig5));
  bin_to_bcd_seq #(.IN_W(16), .DIGITS(4)) u4 (.clk(clk), .rst(rst), .start(start), .enable(enable),
    .bin_in(bin_in), .busy(busy4), .done(done4), .overflow(ovf4), .digits(dig4));

  always #5 clk = ~clk;

  function automatic logic [39:0] model(input longint unsigned v, input int d, input bit en);
    logic [39:0] r = '0;
    longint unsigned lim = 1, p = 1;
    bit lead = 1;
    for (int i = 0; i < d; i++) lim *= 10;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = (v >= lim) ? 4'd9 : 4'((v / p) % 10);
      p *= 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = d - 1; i > 0; i--)
      if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
      else lead = 0;
`endif
    if (!en) for (int i = 0; i < d; i++) r[4*i +: 4] = 4'hF;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic conv(input logic [15:0] v);
    int n;
    @(negedge clk);
    bin_in = v;
    start = 1;
    @(negedge clk);
    start = 0;
    n = 1;
    chk("busy_after_start", busy5, 1);
    while (!done5 && n < 40) begin
      bin_in = 16'($urandom);
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    start = 0;
    chk("latency", n - 1, 17);
    chk("done4_with_done5", done4, 1);
    chk("digits5", dig5, model(v, 5, enable));
    chk("ovf5", ovf5, 0);
    chk("digits4", dig4, model(v, 4, enable));
    chk("ovf4", ovf4, (v > 9999) ? 1 : 0);
    @(negedge clk);
    chk("done_single_pulse", done5, 0);
    chk("digits5_hold", dig5, model(v, 5, enable));
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_busy", busy5, 0);
    chk("rst_done", done5, 0);
    chk("rst_ovf", ovf5, 0);
    chk("rst_digits", dig5, 0);
    enable = 0;
    #1 chk("rst_blank", dig5, 20'hFFFFF);
    enable = 1;
    conv(16'd65535);
    chk("max_exact", dig5, 20'h65535);
    conv(16'd0);
`ifdef LEADING_ZERO_BLANK_EN
    chk("zero_exact", dig5, 20'hFFFF0);
`else
    chk("zero_exact", dig5, 20'h00000);
`endif
    conv(16'd12345);
    chk("sat4_exact", dig4, 16'h9999);
    chk("sat4_ovf", ovf4, 1);
    conv(16'd42);
`ifdef LEADING_ZERO_BLANK_EN
    chk("after_sat4_exact", dig4, 16'hFF42);
`else
    chk("after_sat4_exact", dig4, 16'h0042);
`endif
    chk("after_sat4_ovf", ovf4, 0);
    conv(16'd1234);
    enable = 0;
    #1 chk("enable0_blank", dig5, 20'hFFFFF);
    enable = 1;
`ifdef LEADING_ZERO_BLANK_EN
    #1 chk("enable1_show", dig5, 20'hF1234);
`else
    #1 chk("enable1_show", dig5, 20'h01234);
`endif
    chk("enable_no_done", done5, 0);
    for (int i = 0; i < 20; i++) conv(16'($urandom_range(0, 65535)));
    conv(16'd12345);
    @(negedge clk);
    bin_in = 16'd777;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    start = 1;
    @(negedge clk);
    rst = 0;
    start = 0;
    chk("abort_busy", busy5, 0);
    chk("abort_digits", dig5, 0);
    chk("abort_ovf4", ovf4, 0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      seen |= done5;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_idle", busy5, 0);
    conv(16'd9876);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
